// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NREQ requesters.
// Handles launch/completion handshake, per-frame timeout and a chip-select recovery gap.
module spi_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              spi_tx_enable,
  output logic [DW-1:0]     spi_tx_data,
  input  logic              spi_busy,
  input  logic              spi_done,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    GAP    = 2'b11
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] winner, last_winner, pick;
  logic [TW-1:0] tcnt, tcnt_inc;
  logic [GW-1:0] gcnt;
  logic          found, done_hit, to_hit, to_exp;
  logic [DW-1:0] slot [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DW +: DW];
  end

  // Search begins one past the previous winner, so a requester that keeps
  // asserting req after its ack drops to lowest priority.
  always_comb begin
    int unsigned k;
    k     = 0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NR; i++) begin
      k = (32'(last_winner) + i) % NR;
      if (!found && req[IW'(k)]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
  end

  // Expiry is flagged on the cycle whose increment would reach TIMEOUT, which
  // keeps spi_tx_enable high for exactly TIMEOUT cycles in the no-response case.
  assign tcnt_inc = (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);
  assign to_exp   = (tcnt_inc == TW'(TIMEOUT));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n       = state;
    spi_tx_enable = 1'b0;
    done_hit      = 1'b0;
    to_hit        = 1'b0;
    case (state)
      IDLE: if (found) state_n = LAUNCH;
      LAUNCH: begin
        spi_tx_enable = 1'b1;
        if (to_exp) begin
          to_hit  = 1'b1;
          state_n = GAP;
        end else if (spi_busy) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (spi_done) begin
          done_hit = 1'b1;
          state_n  = GAP;
        end else if (to_exp) begin
          to_hit  = 1'b1;
          state_n = GAP;
        end
      end
      GAP: if (gcnt == GW'(GAP_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt         <= '0;
      ack         <= '0;
      err         <= '0;
      spi_tx_data <= '0;
      winner      <= '0;
      last_winner <= IW'(NREQ - 1);
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt         <= NREQ'(1) << pick;
            winner      <= pick;
            spi_tx_data <= slot[pick];
            tcnt        <= '0;
          end
        end
        LAUNCH, WAIT: begin
          tcnt <= tcnt_inc;
          if (done_hit) ack[winner] <= 1'b1;
          if (to_hit)   err[winner] <= 1'b1;
          if (done_hit || to_hit) begin
            gnt  <= '0;
            gcnt <= '0;
          end
        end
        GAP: begin
          gcnt <= gcnt + GW'(1);
          if (state_n == IDLE) last_winner <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: a round-robin reference model plus a
// procedural SPI master, driven with randomized request patterns and frame lengths.
module tb_spi_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAPC = 4;
  localparam int TMO  = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, gnt, ack, err;
  logic [NREQ*DW-1:0] req_data;
  logic              spi_tx_enable, spi_busy, spi_done, busy;
  logic [DW-1:0]     spi_tx_data;

  int checks = 0;
  int failures = 0;
  int last_w;
  int ack_cnt [NREQ] = '{default: 0};
  int err_cnt [NREQ] = '{default: 0};

  spi_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYCLES(GAPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .err(err), .spi_tx_enable(spi_tx_enable), .spi_tx_data(spi_tx_data),
    .spi_busy(spi_busy), .spi_done(spi_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] === 1'b1) ack_cnt[i]++;
      if (err[i] === 1'b1) err_cnt[i]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requesting index after the previous winner.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last_w + k) % NREQ]) return (last_w + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = 1;
    return v << i;
  endfunction

  function automatic logic [DW-1:0] slot(input logic [NREQ*DW-1:0] d, input int i);
    return d[i*DW +: DW];
  endfunction

  function automatic int sum(input int a [NREQ]);
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += a[i];
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, ack, err} !== '0) begin
      failures++; $display("FAIL reset_vectors: got %h required 0", {gnt, ack, err});
    end
    checks++;
    if ({spi_tx_enable, busy} !== 2'b00) begin
      failures++; $display("FAIL reset_enable_busy: got %b required 00", {spi_tx_enable, busy});
    end
    checks++;
    if (spi_tx_data !== '0) begin
      failures++; $display("FAIL reset_data: got %h required 0", spi_tx_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    last_w = NREQ - 1;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b gnt=%b required 0/0", busy, gnt);
    end
  endtask

  task automatic test_contention();
    int exp, n, g, len, a0;
    a0 = sum(ack_cnt);
    req = '1;
    for (int f = 0; f < 5; f++) begin
      req_data = $urandom;
      exp = model_pick(req);
      n = 0;
      while (gnt === '0 && n < 30) begin tick(); n++; end
      checks++;
      if (gnt !== onehot(exp)) begin
        failures++; $display("FAIL contention_gnt[%0d]: got %b required %b", f, gnt, onehot(exp));
      end
      checks++;
      if (n !== 1 || spi_tx_enable !== 1'b1) begin
        failures++; $display("FAIL contention_latency[%0d]: got %0d cycles en=%b required 1 cycle en=1", f, n, spi_tx_enable);
      end
      checks++;
      if (spi_tx_data !== slot(req_data, exp)) begin
        failures++; $display("FAIL contention_data[%0d]: got %h required %h", f, spi_tx_data, slot(req_data, exp));
      end
      len = $urandom_range(3, 20);
      spi_busy = 1'b1;
      tick();
      repeat (len) tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      spi_busy = 1'b0;
      checks++;
      if (ack !== onehot(exp)) begin
        failures++; $display("FAIL contention_ack[%0d]: got %b required %b", f, ack, onehot(exp));
      end
      g = 0;
      while (busy === 1'b1 && gnt === '0 && g < 40) begin g++; tick(); end
      checks++;
      if (g !== GAPC) begin
        failures++; $display("FAIL contention_gap[%0d]: got %0d required %0d", f, g, GAPC);
      end
      last_w = exp;
    end
    req = '0;
    checks++;
    if (sum(ack_cnt) !== a0 + 5) begin
      failures++; $display("FAIL contention_ack_count: got %0d required %0d", sum(ack_cnt) - a0, 5);
    end
  endtask

  task automatic test_single();
    int a0, e0, g;
    req_data = $urandom;
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || ack !== '0) begin
      failures++; $display("FAIL stray_done_idle: busy=%b ack=%b required 0/0", busy, ack);
    end
    req_data[2*DW +: DW] = 8'hAE;
    req = 4'b0100;
    a0 = ack_cnt[2];
    e0 = sum(err_cnt);
    tick();
    checks++;
    if (gnt !== 4'b0100 || spi_tx_enable !== 1'b1 || spi_tx_data !== 8'hAE) begin
      failures++; $display("FAIL single_grant: gnt=%b en=%b data=%h required 0100/1/ae", gnt, spi_tx_enable, spi_tx_data);
    end
    spi_busy = 1'b1;
    tick();
    checks++;
    if (spi_tx_enable !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0100) begin
      failures++; $display("FAIL single_wait: en=%b busy=%b gnt=%b required 0/1/0100", spi_tx_enable, busy, gnt);
    end
    repeat (69) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    spi_busy = 1'b0;
    req = '0;
    checks++;
    if (ack !== 4'b0100 || gnt !== '0) begin
      failures++; $display("FAIL single_ack: ack=%b gnt=%b required 0100/0000", ack, gnt);
    end
    g = 0;
    while (busy === 1'b1 && g < 40) begin g++; tick(); end
    checks++;
    if (g !== GAPC) begin
      failures++; $display("FAIL single_gap: got %0d required %0d", g, GAPC);
    end
    checks++;
    if (ack_cnt[2] !== a0 + 1 || sum(err_cnt) !== e0) begin
      failures++; $display("FAIL single_pulses: ack=%0d err=%0d required 1/0", ack_cnt[2] - a0, sum(err_cnt) - e0);
    end
    last_w = 2;
  endtask

  task automatic test_timeout();
    int n, g, a0, e0;
    a0 = sum(ack_cnt);
    e0 = err_cnt[1];
    req = 4'b0010;
    n = 0;
    while (gnt === '0 && n < 30) begin tick(); n++; end
    checks++;
    if (gnt !== 4'b0010) begin
      failures++; $display("FAIL timeout_gnt: got %b required 0010", gnt);
    end
    n = 0;
    while (spi_tx_enable === 1'b1 && n < 400) begin
      spi_done = (n == 10);
      tick();
      n++;
    end
    spi_done = 1'b0;
    checks++;
    if (n !== TMO) begin
      failures++; $display("FAIL timeout_enable_cycles: got %0d required %0d", n, TMO);
    end
    checks++;
    if (err !== 4'b0010 || ack !== '0 || gnt !== '0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_err: err=%b ack=%b gnt=%b busy=%b required 0010/0000/0000/1", err, ack, gnt, busy);
    end
    req = '0;
    g = 0;
    while (busy === 1'b1 && g < 40) begin g++; tick(); end
    checks++;
    if (g !== GAPC || err_cnt[1] !== e0 + 1 || sum(ack_cnt) !== a0) begin
      failures++; $display("FAIL timeout_after: gap=%0d err=%0d ack=%0d required %0d/1/0", g, err_cnt[1] - e0, sum(ack_cnt) - a0, GAPC);
    end
    last_w = 1;
  endtask

  task automatic test_race();
    int r, n, g, e0;
    r = $urandom_range(0, NREQ - 1);
    e0 = sum(err_cnt);
    req = onehot(r);
    n = 0;
    while (gnt === '0 && n < 30) begin tick(); n++; end
    checks++;
    if (gnt !== onehot(model_pick(onehot(r)) >= 0 ? r : 0)) begin
      failures++; $display("FAIL race_gnt: got %b required %b", gnt, onehot(r));
    end
    spi_busy = 1'b1;
    repeat (TMO - 1) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    spi_busy = 1'b0;
    req = '0;
    checks++;
    if (ack !== onehot(r) || err !== '0) begin
      failures++; $display("FAIL race_ack_wins: ack=%b err=%b required %b/0000", ack, err, onehot(r));
    end
    g = 0;
    while (busy === 1'b1 && g < 40) begin g++; tick(); end
    checks++;
    if (sum(err_cnt) !== e0) begin
      failures++; $display("FAIL race_no_err: got %0d err pulses required 0", sum(err_cnt) - e0);
    end
    last_w = r;
  endtask

  task automatic test_reset_mid();
    int n, g, a0, e0, exp;
    req = 4'b0100;
    n = 0;
    while (gnt === '0 && n < 30) begin tick(); n++; end
    spi_busy = 1'b1;
    repeat (10) tick();
    a0 = sum(ack_cnt);
    e0 = sum(err_cnt);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, ack, err, spi_tx_data} !== '0 || spi_tx_enable !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_async: gnt=%b ack=%b err=%b data=%h en=%b busy=%b required all 0", gnt, ack, err, spi_tx_data, spi_tx_enable, busy);
    end
    spi_busy = 1'b0;
    req = 4'b1010;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    last_w = NREQ - 1;
    exp = model_pick(req);
    n = 0;
    while (gnt === '0 && n < 30) begin tick(); n++; end
    checks++;
    if (gnt !== onehot(exp) || n !== 1) begin
      failures++; $display("FAIL reset_mid_first_winner: gnt=%b after %0d cycles required %b after 1", gnt, n, onehot(exp));
    end
    spi_busy = 1'b1;
    repeat (5) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    spi_busy = 1'b0;
    req = '0;
    checks++;
    if (ack !== onehot(exp)) begin
      failures++; $display("FAIL reset_mid_ack: got %b required %b", ack, onehot(exp));
    end
    g = 0;
    while (busy === 1'b1 && g < 40) begin g++; tick(); end
    checks++;
    if (sum(ack_cnt) !== a0 + 1 || sum(err_cnt) !== e0) begin
      failures++; $display("FAIL reset_mid_pulses: ack=%0d err=%0d required 1/0", sum(ack_cnt) - a0, sum(err_cnt) - e0);
    end
    last_w = exp;
  endtask

  task automatic test_drop();
    int exp, n, g, len;
    logic [DW-1:0] d;
    for (int it = 0; it < 6; it++) begin
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_data = $urandom;
      exp = model_pick(req);
      d = slot(req_data, exp);
      n = 0;
      while (gnt === '0 && n < 30) begin tick(); n++; end
      checks++;
      if (gnt !== onehot(exp) || spi_tx_data !== d) begin
        failures++; $display("FAIL drop_grant[%0d]: gnt=%b data=%h required %b/%h", it, gnt, spi_tx_data, onehot(exp), d);
      end
      spi_busy = 1'b1;
      tick();
      req[exp] = 1'b0;
      req_data[exp*DW +: DW] = ~d;
      len = $urandom_range(2, 30);
      repeat (len) tick();
      checks++;
      if (spi_tx_data !== d || gnt !== onehot(exp)) begin
        failures++; $display("FAIL drop_data_stable[%0d]: data=%h gnt=%b required %h/%b", it, spi_tx_data, gnt, d, onehot(exp));
      end
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      spi_busy = 1'b0;
      req = '0;
      checks++;
      if (ack !== onehot(exp) || err !== '0) begin
        failures++; $display("FAIL drop_ack[%0d]: ack=%b err=%b required %b/0000", it, ack, err, onehot(exp));
      end
      g = 0;
      while (busy === 1'b1 && g < 40) begin g++; tick(); end
      checks++;
      if (g !== GAPC) begin
        failures++; $display("FAIL drop_gap[%0d]: got %0d required %0d", it, g, GAPC);
      end
      last_w = exp;
    end
  endtask

  initial begin
    req = '0;
    req_data = '0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_race();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
